// File: rtl/m4.sv
// 4:1 data selector with an optional output register.
// Each bit position is its own lane, so the select decode sits next to its data.

module m4_lane (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb begin
    y = d[0];
    case (sel)
      2'b01:   y = d[1];
      2'b10:   y = d[2];
      2'b11:   y = d[3];
      default: y = d[0];
    endcase
  end
endmodule

module m4 #(
  parameter int WIDTH   = 1,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic             sel1,
  input  logic             sel2,
  output logic [WIDTH-1:0] out
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] mux;

  assign sel = {sel1, sel2};

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    m4_lane u_lane (
      .d   ({i4[g], i3[g], i2[g], i1[g]}),
      .sel (sel),
      .y   (mux[g])
    );
  end

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] q;
    // Reset wins over data so a pending selection is discarded.
    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= mux;
    end
    assign out = q;
  end else begin : g_comb
    assign out = mux;
  end
endmodule

// File: tb/tb_m4.sv
// Directed bench for m4: registered 1-bit and 8-bit variants plus a combinational 4-bit variant.

module tb_m4;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  // WIDTH=1, registered
  logic rst1 = 1'b0;
  logic a1 = 0, a2 = 0, a3 = 0, a4 = 0, as1 = 0, as2 = 0;
  logic o1;
  // WIDTH=8, registered
  logic       rst8 = 1'b0;
  logic [7:0] b1 = 0, b2 = 0, b3 = 0, b4 = 0;
  logic       bs1 = 0, bs2 = 0;
  logic [7:0] o8;
  // WIDTH=4, combinational
  logic       rst4 = 1'b0;
  logic [3:0] c1 = 0, c2 = 0, c3 = 0, c4 = 0;
  logic       cs1 = 0, cs2 = 0;
  logic [3:0] o4;

  m4 #(.WIDTH(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst1), .i1(a1), .i2(a2), .i3(a3), .i4(a4),
    .sel1(as1), .sel2(as2), .out(o1));
  m4 #(.WIDTH(8), .OUT_REG(1)) u8 (
    .clk(clk), .rst(rst8), .i1(b1), .i2(b2), .i3(b3), .i4(b4),
    .sel1(bs1), .sel2(bs2), .out(o8));
  m4 #(.WIDTH(4), .OUT_REG(0)) u4 (
    .clk(clk), .rst(rst4), .i1(c1), .i2(c2), .i3(c3), .i4(c4),
    .sel1(cs1), .sel2(cs2), .out(o4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] v;
    logic       e;
    logic [3:0] oh;

    // Reset: two edges with all inputs 1, sel=00
    rst1 = 1; rst8 = 1;
    a1 = 1; a2 = 1; a3 = 1; a4 = 1; as1 = 0; as2 = 0;
    tick; chk("rst_edge1", 64'(o1), 64'd0); chk("rst8_edge1", 64'(o8), 64'd0);
    tick; chk("rst_edge2", 64'(o1), 64'd0);
    rst1 = 0;
    tick; chk("rst_release", 64'(o1), 64'd1);

    // Exhaustive sweep of {sel1,sel2,i1,i2,i3,i4}
    for (int k = 0; k < 64; k++) begin
      v = 6'(k);
      {as1, as2, a1, a2, a3, a4} = v;
      case (v[5:4])
        2'b00: e = v[3];
        2'b01: e = v[2];
        2'b10: e = v[1];
        default: e = v[0];
      endcase
      tick; chk($sformatf("sweep_%0d", k), 64'(o1), 64'(e));
    end

    // One-hot data, sel stepping 00..11
    for (int h = 0; h < 4; h++) begin
      oh = 4'b0001 << h;
      {a4, a3, a2, a1} = oh;
      for (int s = 0; s < 4; s++) begin
        {as1, as2} = 2'(s);
        tick; chk($sformatf("onehot_i%0d_s%0d", h + 1, s), 64'(o1), 64'(s == h));
      end
    end

    // Hold between edges
    {a1, a2, a3, a4} = 4'b1000; {as1, as2} = 2'b00;
    tick; chk("hold_load", 64'(o1), 64'd1);
    a1 = 0;              #1 chk("hold_a", 64'(o1), 64'd1);
    {as1, as2} = 2'b11;  #1 chk("hold_b", 64'(o1), 64'd1);
    a4 = 1; a1 = 1;      #1 chk("hold_c", 64'(o1), 64'd1);
    {as1, as2} = 2'b01; a2 = 0;
    tick; chk("hold_next_edge", 64'(o1), 64'd0);

    // Mid-operation reset on 8-bit instance
    b1 = 8'h11; b2 = 8'h22; b3 = 8'hA5; b4 = 8'h44; {bs1, bs2} = 2'b10;
    rst8 = 0;
    tick; chk("w8_load", 64'(o8), 64'hA5);
    rst8 = 1;
    tick; chk("w8_rst", 64'(o8), 64'h00);
    rst8 = 0;
    tick; chk("w8_resume", 64'(o8), 64'hA5);
    // Data and select change together: new select picks new data
    b2 = 8'h3C; {bs1, bs2} = 2'b01;
    tick; chk("w8_simul", 64'(o8), 64'h3C);
    b1 = 8'hFF; b3 = 8'h00; b4 = 8'h5A;
    tick; chk("w8_unsel", 64'(o8), 64'h3C);

    // Combinational variant
    c1 = 4'h1; c2 = 4'h2; c3 = 4'h4; c4 = 4'h8;
    for (int s = 0; s < 4; s++) begin
      {cs1, cs2} = 2'(s);
      #1 chk($sformatf("comb_s%0d", s), 64'(o4), 64'(4'h1 << s));
    end
    rst4 = 1;
    #1 chk("comb_rst", 64'(o4), 64'h8);
    tick; chk("comb_rst_edge", 64'(o4), 64'h8);
    {cs1, cs2} = 2'b01;
    #1 chk("comb_rst_sel", 64'(o4), 64'h2);
    rst4 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
